// File: rtl/uart_cmd_responder_pkg.sv
// Shared definitions for the control UART link: command bytes, responder FSM
// states and small helpers used by both the responder and the transmitter top.
package uart_cmd_responder_pkg;

  localparam logic [7:0] CMD_ON     = 8'hE6;
  localparam logic [7:0] CMD_OFF    = 8'hDA;
  localparam logic [7:0] CMD_TOGGLE = 8'h4D;
  localparam logic [7:0] CMD_ACK    = 8'h3C;
  localparam logic [7:0] CMD_NACK   = 8'hC3;

  // 2 s of silence at 48 MHz before the output is forced off
  localparam int unsigned TIMEOUT_CYCLES_DEF = 96000000;
  localparam int unsigned START_WAIT_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } resp_state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Byte-level handshake between the responder and the local uart_rx/uart_tx.
// The master side is the UART pair, the slave side is the responder.
interface uart_cmd_responder_if;
  logic [7:0] data_received;
  logic       rx_done;
  logic       parity_error;
  logic       tx_busy;
  logic [7:0] data_to_tx;
  logic       start_tx;

  modport master (
    output data_received, rx_done, parity_error, tx_busy,
    input  data_to_tx, start_tx
  );

  modport slave (
    input  data_received, rx_done, parity_error, tx_busy,
    output data_to_tx, start_tx
  );
endinterface

// File: rtl/uart_cmd_responder_link_watchdog.sv
// Link watchdog: counts cycles since the last accepted command and flags
// expiry. The counter parks at its terminal value rather than wrapping, so
// the expired condition persists until the next reload.
module uart_cmd_responder_link_watchdog
  import uart_cmd_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic expire,
  output logic link_timeout
);

  localparam logic [31:0] LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] count;

  // A reload in the same cycle as expiry wins, so no forced off then
  assign expire = (count == LAST) && !reload;

  // Counter with reload-to-zero, hold at terminal value, sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      link_timeout <= 1'b0;
    end else if (reload) begin
      count        <= '0;
      link_timeout <= 1'b0;
    end else if (count == LAST) begin
      link_timeout <= 1'b1;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Command receiver for the control UART link on each FPGA_modulo submodule.
// Decodes ON/OFF/TOGGLE bytes into the SPWM output enable, answers each
// command with ACK or NACK through uart_tx, and forces the output off when
// the link goes quiet for too long.
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned START_WAIT     = START_WAIT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_cmd_responder_if.slave        bus,
  output logic                       out_enable,
  output logic                       link_timeout,
  output logic [7:0]                 err_count
);

  localparam logic [15:0] WAIT_LAST = 16'(START_WAIT - 1);

  resp_state_t state, state_next;
  logic [7:0]  rx_byte;
  logic        rx_parity;
  logic        start_tx_q, start_tx_next;
  logic [7:0]  tx_byte_q, tx_byte_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic        enable_cmd, enable_next;
  logic        reload, expire, err_inc;

  uart_cmd_responder_link_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .reload       (reload),
    .expire       (expire),
    .link_timeout (link_timeout)
  );

  assign bus.start_tx   = start_tx_q;
  assign bus.data_to_tx = tx_byte_q;

  // Next-state, reply, handshake and enable decisions for the responder FSM
  always_comb begin
    state_next    = state;
    start_tx_next = start_tx_q;
    tx_byte_next  = tx_byte_q;
    wait_cnt_next = wait_cnt;
    enable_cmd    = out_enable;
    reload        = 1'b0;
    err_inc       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.rx_done) state_next = DECODE;
      end
      DECODE: begin
        state_next = SEND;
        if (rx_parity) begin
          tx_byte_next = CMD_NACK;
          err_inc      = 1'b1;
        end else begin
          case (rx_byte)
            CMD_ON: begin
              enable_cmd   = 1'b1;
              reload       = 1'b1;
              tx_byte_next = CMD_ACK;
            end
            CMD_OFF: begin
              enable_cmd   = 1'b0;
              reload       = 1'b1;
              tx_byte_next = CMD_ACK;
            end
            CMD_TOGGLE: begin
              enable_cmd   = ~out_enable;
              reload       = 1'b1;
              tx_byte_next = CMD_ACK;
            end
            CMD_ACK: begin
              state_next = IDLE;
            end
            default: begin
              tx_byte_next = CMD_NACK;
              err_inc      = 1'b1;
            end
          endcase
        end
      end
      SEND: begin
        if (start_tx_q) begin
          if (bus.tx_busy) begin
            start_tx_next = 1'b0;
            state_next    = WAIT_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            start_tx_next = 1'b0;
            err_inc       = 1'b1;
            state_next    = IDLE;
          end else begin
            wait_cnt_next = wait_cnt + 16'd1;
          end
        end else if (!bus.tx_busy) begin
          start_tx_next = 1'b1;
          wait_cnt_next = '0;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_next = IDLE;
      end
    endcase

    // A byte arriving while busy is dropped; all error sources merge into one increment
    if (bus.rx_done && state != IDLE) err_inc = 1'b1;

    if (reload)      enable_next = enable_cmd;
    else if (expire) enable_next = 1'b0;
    else             enable_next = enable_cmd;
  end

  // State and datapath registers, cleared asynchronously by the shared reset net
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rx_byte    <= '0;
      rx_parity  <= 1'b0;
      start_tx_q <= 1'b0;
      tx_byte_q  <= CMD_ACK;
      wait_cnt   <= '0;
      out_enable <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_next;
      start_tx_q <= start_tx_next;
      tx_byte_q  <= tx_byte_next;
      wait_cnt   <= wait_cnt_next;
      out_enable <= enable_next;
      if (state == IDLE && bus.rx_done) begin
        rx_byte   <= bus.data_received;
        rx_parity <= bus.parity_error;
      end
      if (err_inc) err_count <= sat_inc8(err_count);
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder. uart_rx/uart_tx are modelled at
// the byte interface; expected reply bytes go into a queue when a command is
// driven and are compared against the bytes the tx model captures.
module tb_uart_cmd_responder;
  import uart_cmd_responder_pkg::*;

  localparam int unsigned TB_TIMEOUT = 1000;
  localparam int          BUSY_LEN   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       out_enable;
  logic       link_timeout;
  logic [7:0] err_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         tx_auto = 1'b1;
  logic       model_en = 1'b0;
  logic [7:0] model_err = 8'd0;

  uart_cmd_responder_if bus();

  uart_cmd_responder #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .START_WAIT    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .out_enable   (out_enable),
    .link_timeout (link_timeout),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // uart_tx model: accepts start_tx, captures the byte, stays busy a while
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_auto && reset && bus.start_tx && !bus.tx_busy) begin
        got_q.push_back(bus.data_to_tx);
        bus.tx_busy = 1'b1;
        repeat (BUSY_LEN) @(negedge clk);
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Drive one rx_done strobe and record what the responder should do with it
  task automatic send_byte(input logic [7:0] b, input bit par, input bit accepted);
    bus.data_received = b;
    bus.parity_error  = par;
    bus.rx_done       = 1'b1;
    @(negedge clk);
    bus.rx_done      = 1'b0;
    bus.parity_error = 1'b0;
    if (!accepted) begin
      if (model_err != 8'hFF) model_err = model_err + 8'd1;
    end else if (par) begin
      exp_q.push_back(CMD_NACK);
      if (model_err != 8'hFF) model_err = model_err + 8'd1;
    end else begin
      case (b)
        CMD_ON:     begin model_en = 1'b1;      exp_q.push_back(CMD_ACK); end
        CMD_OFF:    begin model_en = 1'b0;      exp_q.push_back(CMD_ACK); end
        CMD_TOGGLE: begin model_en = ~model_en; exp_q.push_back(CMD_ACK); end
        CMD_ACK:    ;
        default: begin
          exp_q.push_back(CMD_NACK);
          if (model_err != 8'hFF) model_err = model_err + 8'd1;
        end
      endcase
    end
  endtask

  // Bounded wait until n replies were captured and the transmitter is idle
  task automatic wait_replies(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (got_q.size() >= n && !bus.tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (out_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable got %b exp 0", out_enable); end
    checks++; if (bus.start_tx !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got %b exp 0", bus.start_tx); end
    checks++; if (bus.data_to_tx !== CMD_ACK) begin errors++; $display("[TB] FAIL reset_data got %h exp %h", bus.data_to_tx, CMD_ACK); end
    checks++; if (link_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b exp 0", link_timeout); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_err got %0d exp 0", err_count); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_on();
    bit ok;
    logic [7:0] e, g;
    send_byte(CMD_ON, 1'b0, 1'b1);
    checks++; if (out_enable !== 1'b0) begin errors++; $display("[TB] FAIL on_enable_early got %b exp 0", out_enable); end
    @(negedge clk);
    checks++; if (out_enable !== 1'b1) begin errors++; $display("[TB] FAIL on_enable_2cyc got %b exp 1", out_enable); end
    @(negedge clk);
    checks++; if (bus.start_tx !== 1'b1) begin errors++; $display("[TB] FAIL on_start_rise got %b exp 1", bus.start_tx); end
    checks++; if (bus.data_to_tx !== CMD_ACK) begin errors++; $display("[TB] FAIL on_data got %h exp %h", bus.data_to_tx, CMD_ACK); end
    @(negedge clk);
    checks++; if (bus.start_tx !== 1'b0) begin errors++; $display("[TB] FAIL on_start_fall got %b exp 0", bus.start_tx); end
    wait_replies(1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL on_reply_wait got timeout exp reply"); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL on_reply_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("[TB] FAIL on_reply got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_toggle();
    bit ok;
    logic [7:0] e, g;
    send_byte(CMD_TOGGLE, 1'b0, 1'b1);
    wait_replies(1, ok);
    checks++; if (out_enable !== model_en) begin errors++; $display("[TB] FAIL toggle1_enable got %b exp %b", out_enable, model_en); end
    send_byte(CMD_TOGGLE, 1'b0, 1'b1);
    wait_replies(2, ok);
    checks++; if (out_enable !== model_en) begin errors++; $display("[TB] FAIL toggle2_enable got %b exp %b", out_enable, model_en); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL toggle_reply_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("[TB] FAIL toggle_reply got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_off();
    bit ok;
    logic [7:0] e, g;
    send_byte(CMD_OFF, 1'b0, 1'b1);
    wait_replies(1, ok);
    checks++; if (out_enable !== 1'b0) begin errors++; $display("[TB] FAIL off_enable got %b exp 0", out_enable); end
    send_byte(CMD_ON, 1'b0, 1'b1);
    wait_replies(2, ok);
    checks++; if (out_enable !== 1'b1) begin errors++; $display("[TB] FAIL off_reon_enable got %b exp 1", out_enable); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL off_reply_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("[TB] FAIL off_reply got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_nack();
    bit ok;
    logic [7:0] e, g;
    send_byte(8'h55, 1'b0, 1'b1);
    wait_replies(1, ok);
    send_byte(CMD_ON, 1'b1, 1'b1);
    wait_replies(2, ok);
    checks++; if (out_enable !== model_en) begin errors++; $display("[TB] FAIL nack_enable got %b exp %b", out_enable, model_en); end
    checks++; if (err_count !== model_err) begin errors++; $display("[TB] FAIL nack_err got %0d exp %0d", err_count, model_err); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL nack_reply_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("[TB] FAIL nack_reply got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overrun();
    bit ok;
    bit seen_busy;
    logic [7:0] e, g;
    send_byte(CMD_ON, 1'b0, 1'b1);
    seen_busy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_busy) begin
        seen_busy = 1'b1;
        break;
      end
    end
    checks++; if (!seen_busy) begin errors++; $display("[TB] FAIL overrun_busy_wait got timeout exp tx_busy"); end
    @(negedge clk);
    send_byte(CMD_TOGGLE, 1'b0, 1'b0);
    wait_replies(1, ok);
    repeat (5) @(negedge clk);
    checks++; if (err_count !== model_err) begin errors++; $display("[TB] FAIL overrun_err got %0d exp %0d", err_count, model_err); end
    checks++; if (out_enable !== model_en) begin errors++; $display("[TB] FAIL overrun_enable got %b exp %b", out_enable, model_en); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL overrun_reply_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("[TB] FAIL overrun_reply got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_watchdog();
    bit ok;
    logic [7:0] e, g;
    send_byte(CMD_ON, 1'b0, 1'b1);
    repeat (TB_TIMEOUT) @(negedge clk);
    checks++; if (link_timeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_early_timeout got %b exp 0", link_timeout); end
    checks++; if (out_enable !== 1'b1) begin errors++; $display("[TB] FAIL wd_early_enable got %b exp 1", out_enable); end
    @(negedge clk);
    model_en = 1'b0;
    checks++; if (link_timeout !== 1'b1) begin errors++; $display("[TB] FAIL wd_timeout got %b exp 1", link_timeout); end
    checks++; if (out_enable !== 1'b0) begin errors++; $display("[TB] FAIL wd_forced_off got %b exp 0", out_enable); end
    send_byte(CMD_ON, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (link_timeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_clear got %b exp 0", link_timeout); end
    checks++; if (out_enable !== 1'b1) begin errors++; $display("[TB] FAIL wd_reon got %b exp 1", out_enable); end
    wait_replies(2, ok);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL wd_reply_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("[TB] FAIL wd_reply got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_start_wait();
    int high_cycles;
    tx_auto = 1'b0;
    send_byte(CMD_OFF, 1'b0, 1'b1);
    high_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.start_tx) high_cycles++;
    end
    if (model_err != 8'hFF) model_err = model_err + 8'd1;
    checks++; if (high_cycles != 16) begin errors++; $display("[TB] FAIL sw_start_len got %0d exp 16", high_cycles); end
    checks++; if (bus.start_tx !== 1'b0) begin errors++; $display("[TB] FAIL sw_start_low got %b exp 0", bus.start_tx); end
    checks++; if (err_count !== model_err) begin errors++; $display("[TB] FAIL sw_err got %0d exp %0d", err_count, model_err); end
    send_byte(CMD_ACK, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (err_count !== model_err) begin errors++; $display("[TB] FAIL sw_idle_err got %0d exp %0d", err_count, model_err); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_send();
    send_byte(CMD_ON, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (bus.start_tx !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_start got %b exp 1", bus.start_tx); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_enable !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_enable got %b exp 0", out_enable); end
    checks++; if (bus.start_tx !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_start got %b exp 0", bus.start_tx); end
    checks++; if (bus.data_to_tx !== CMD_ACK) begin errors++; $display("[TB] FAIL rst_async_data got %h exp %h", bus.data_to_tx, CMD_ACK); end
    checks++; if (link_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_timeout got %b exp 0", link_timeout); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL rst_async_err got %0d exp 0", err_count); end
    @(negedge clk);
    reset = 1'b1;
    model_en = 1'b0;
    model_err = 8'd0;
    exp_q.delete(); got_q.delete();
    @(negedge clk);
  endtask

  // Scenario sequence
  initial begin
    bus.data_received = 8'h00;
    bus.rx_done       = 1'b0;
    bus.parity_error  = 1'b0;
    test_reset();
    test_on();
    test_toggle();
    test_off();
    test_nack();
    test_overrun();
    test_watchdog();
    test_start_wait();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
